// File: rtl/pulse_sync_sched.sv
// Round-robin scheduler sharing one pulse_sync crossing between NUM_REQ event sources.
// Pending events are counted per requester; each grant issues one pulse and waits for ack or timeout.
module pulse_sync_sched #(
    parameter int NUM_REQ    = 4,
    parameter int CNT_W      = 4,
    parameter int TIMEOUT    = 64,
    parameter int GAP_CYCLES = 2,
    parameter int IDW        = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_enable,
    input  logic [NUM_REQ-1:0] i_req_pulse,
    output logic [NUM_REQ-1:0] o_req_ovf,
    output logic [NUM_REQ-1:0] o_pending,
    output logic               o_pulse,
    output logic [IDW-1:0]     o_id,
    input  logic               i_ack,
    output logic               o_busy,
    output logic               o_timeout
);

    // state    | meaning
    // IDLE     | waiting for enable and a pending event
    // ISSUE    | o_pulse high for this single cycle
    // WAIT_ACK | ack timer running, waiting for returned ack
    // GAP      | enforced idle gap before the next grant

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0]    TMR_LOAD = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0]    GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, GAP} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt [NUM_REQ];
    logic [NUM_REQ-1:0] dec;
    logic [IDW-1:0]     ptr, gnt_idx;
    logic               gnt_found, grant;
    logic [TW-1:0]      ack_tmr;
    logic [GW-1:0]      gap_tmr;
    logic               ack_tc, gap_tc;

    always_comb begin
        o_pending = '0;
        for (int k = 0; k < NUM_REQ; k++) o_pending[k] = (cnt[k] != '0);
    end

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        int j;
        j         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!gnt_found && o_pending[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(j);
            end
        end
    end

    assign grant = (state == IDLE) && i_enable && gnt_found;

    always_comb begin
        dec = '0;
        if (grant) dec[gnt_idx] = 1'b1;
    end

    always_comb begin
        o_req_ovf = '0;
        for (int k = 0; k < NUM_REQ; k++)
            o_req_ovf[k] = i_req_pulse[k] && (cnt[k] == CNT_MAX) && !dec[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REQ; k++) cnt[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (i_req_pulse[k] && !dec[k] && (cnt[k] != CNT_MAX))
                    cnt[k] <= cnt[k] + 1'b1;
                else if (dec[k] && !i_req_pulse[k])
                    cnt[k] <= cnt[k] - 1'b1;
            end
        end
    end

    // Pointer resets to the last index so requester 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr  <= IDW'(NUM_REQ - 1);
            o_id <= '0;
        end else if (grant) begin
            ptr  <= gnt_idx;
            o_id <= gnt_idx;
        end
    end

    assign ack_tc = (ack_tmr == '0);
    assign gap_tc = (gap_tmr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_tmr <= '0;
            gap_tmr <= '0;
        end else begin
            if (state == ISSUE)
                ack_tmr <= TMR_LOAD;
            else if (state == WAIT_ACK && !ack_tc)
                ack_tmr <= ack_tmr - 1'b1;
            if (state_nxt == GAP && state != GAP)
                gap_tmr <= GAP_LOAD;
            else if (state == GAP && !gap_tc)
                gap_tmr <= gap_tmr - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (grant) state_nxt = ISSUE;
            ISSUE:    state_nxt = WAIT_ACK;
            WAIT_ACK: if (i_ack || ack_tc) state_nxt = HAS_GAP ? GAP : IDLE;
            GAP:      if (gap_tc) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_pulse   = (state == ISSUE);
        o_busy    = (state != IDLE);
        o_timeout = (state == WAIT_ACK) && ack_tc && !i_ack;
    end

endmodule

// File: tb/tb_pulse_sync_sched.sv
// Directed bench for pulse_sync_sched: expected grant IDs go into a queue,
// a negedge monitor pops and compares them whenever o_pulse is seen.
module tb_pulse_sync_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       i_enable = 1'b0;
    logic       i_ack = 1'b0;
    logic [3:0] i_req_pulse = 4'b0;
    logic [3:0] o_req_ovf, o_pending;
    logic       o_pulse, o_busy, o_timeout;
    logic [1:0] o_id;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_q[$];

    pulse_sync_sched #(
        .NUM_REQ(4), .CNT_W(4), .TIMEOUT(64), .GAP_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_req_pulse(i_req_pulse),
        .o_req_ovf(o_req_ovf), .o_pending(o_pending), .o_pulse(o_pulse), .o_id(o_id),
        .i_ack(i_ack), .o_busy(o_busy), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && o_pulse) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_pulse actual_id=%0d required=no_pulse", o_id);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(o_id) != e) begin
                    failures++;
                    $display("FAIL sb_grant_id actual=%0d required=%0d", o_id, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int max_cyc, output int pcyc);
        bit ok;
        ok = 1'b0;
        pcyc = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (o_pulse) begin
                ok = 1'b1;
                pcyc = cyc;
                break;
            end
            step();
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_pulse no o_pulse within %0d cycles", max_cyc);
        end
    endtask

    // Called at the negedge of ISSUE; drives i_ack on the n-th WAIT_ACK cycle.
    task automatic ack_after(input int n);
        repeat (n) step();
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
    endtask

    task automatic pulse_req(input logic [3:0] r);
        i_req_pulse = r;
        step();
        i_req_pulse = 4'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_enable = 1'b0;
        i_ack = 1'b0;
        i_req_pulse = 4'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int p0, p1, p2, p3, p4;
        bit early_to;

        // reset state
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'({o_pulse, o_busy, o_timeout, o_id, o_pending, o_req_ovf}), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // single event on requester 2
        i_enable = 1'b1;
        exp_q.push_back(2);
        i_req_pulse = 4'b0100;
        @(negedge clk);
        chk("single_pulse_c0", 32'(o_pulse), 32'h0);
        step();
        i_req_pulse = 4'b0;
        @(negedge clk);
        chk("single_pending_c1", 32'(o_pending), 32'h4);
        chk("single_pulse_c1", 32'(o_pulse), 32'h0);
        step();
        @(negedge clk);
        chk("single_pulse_c2", 32'(o_pulse), 32'h1);
        chk("single_busy_issue", 32'(o_busy), 32'h1);
        repeat (9) step();
        @(negedge clk);
        chk("single_pulse_wait", 32'(o_pulse), 32'h0);
        ack_after(1);
        @(negedge clk);
        chk("single_busy_gap1", 32'(o_busy), 32'h1);
        step();
        @(negedge clk);
        chk("single_busy_gap2", 32'(o_busy), 32'h1);
        step();
        @(negedge clk);
        chk("single_busy_idle", 32'(o_busy), 32'h0);
        chk("single_pending_end", 32'(o_pending), 32'h0);
        chk("single_id_held", 32'(o_id), 32'h2);

        // round robin 0,1,2,3 then 1,3
        do_reset();
        i_enable = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        pulse_req(4'b1111);
        wait_pulse(10, p0); ack_after(5);
        wait_pulse(20, p1); ack_after(5);
        wait_pulse(20, p2); ack_after(5);
        wait_pulse(20, p3); ack_after(5);
        chk("rr_spacing_01", 32'(p1 - p0), 32'd9);
        chk("rr_spacing_12", 32'(p2 - p1), 32'd9);
        chk("rr_spacing_23", 32'(p3 - p2), 32'd9);
        repeat (4) step();
        exp_q.push_back(1); exp_q.push_back(3);
        pulse_req(4'b1010);
        wait_pulse(10, p0); ack_after(5);
        wait_pulse(20, p1); ack_after(5);
        chk("rr_follow_spacing", 32'(p1 - p0), 32'd9);

        // saturation with enable low
        do_reset();
        for (int n = 1; n <= 17; n++) begin
            i_req_pulse = 4'b0001;
            @(negedge clk);
            chk($sformatf("sat_ovf_%0d", n), 32'(o_req_ovf), (n >= 16) ? 32'h1 : 32'h0);
            step();
            i_req_pulse = 4'b0;
            step();
        end
        chk("sat_pending", 32'(o_pending), 32'h1);
        chk("sat_idle_busy", 32'(o_busy), 32'h0);
        i_enable = 1'b1;
        for (int n = 0; n < 15; n++) begin
            exp_q.push_back(0);
            wait_pulse(10, p0);
            ack_after(1);
        end
        repeat (20) step();
        chk("sat_drained_q", 32'(exp_q.size()), 32'h0);
        chk("sat_pending_end", 32'(o_pending), 32'h0);

        // timeout, then requester 1, then ack on the 64th cycle
        do_reset();
        i_enable = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1);
        pulse_req(4'b0011);
        wait_pulse(10, p0);
        step();
        early_to = 1'b0;
        for (int c = 1; c < 64; c++) begin
            @(negedge clk);
            if (o_timeout) early_to = 1'b1;
            step();
        end
        chk("to_early", 32'(early_to), 32'h0);
        @(negedge clk);
        chk("to_cycle64", 32'(o_timeout), 32'h1);
        step();
        @(negedge clk);
        chk("to_gap_flag", 32'(o_timeout), 32'h0);
        chk("to_gap_busy", 32'(o_busy), 32'h1);
        wait_pulse(10, p1);
        chk("to_spacing", 32'(p1 - p0), 32'd68);
        step();
        for (int c = 1; c < 64; c++) step();
        i_ack = 1'b1;
        @(negedge clk);
        chk("ack_vs_timeout", 32'(o_timeout), 32'h0);
        step();
        i_ack = 1'b0;
        @(negedge clk);
        chk("ack_vs_timeout_gap", 32'(o_busy), 32'h1);
        repeat (3) step();

        // increment on the grant edge of the same requester
        do_reset();
        i_enable = 1'b1;
        exp_q.push_back(2); exp_q.push_back(2);
        pulse_req(4'b0100);
        pulse_req(4'b0100);
        @(negedge clk);
        chk("coinc_issue", 32'(o_pulse), 32'h1);
        chk("coinc_pending", 32'(o_pending), 32'h4);
        ack_after(2);
        wait_pulse(10, p4);
        ack_after(1);
        repeat (4) step();
        @(negedge clk);
        chk("coinc_pending_end", 32'(o_pending), 32'h0);

        // stray ack in IDLE
        i_ack = 1'b1;
        @(negedge clk);
        chk("stray_ack_busy", 32'(o_busy), 32'h0);
        chk("stray_ack_to", 32'(o_timeout), 32'h0);
        step();
        i_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_after", 32'(o_busy), 32'h0);
        repeat (5) step();

        // reset during WAIT_ACK with 3 events pending
        do_reset();
        i_enable = 1'b1;
        exp_q.push_back(0);
        pulse_req(4'b1111);
        wait_pulse(10, p0);
        repeat (3) step();
        @(negedge clk);
        chk("rst_mid_busy", 32'(o_busy), 32'h1);
        chk("rst_mid_pending", 32'(o_pending), 32'he);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", 32'({o_pulse, o_busy, o_timeout, o_id, o_pending, o_req_ovf}), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        repeat (20) step();
        @(negedge clk);
        chk("rst_after_busy", 32'(o_busy), 32'h0);
        chk("rst_after_pending", 32'(o_pending), 32'h0);
        exp_q.push_back(3);
        pulse_req(4'b1000);
        wait_pulse(10, p0);
        ack_after(1);
        repeat (5) step();
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_sync_sched.md
Name: pulse_sync_sched

Overview:
- Single-clock scheduler that shares one pulse_sync crossing channel between NUM_REQ local event sources.
- Counts pending events per requester and grants requesters round-robin.
- Issues one single-cycle pulse with a held requester ID per grant, then waits for the return acknowledge (a pulse_sync in the reverse direction) or a timeout.
- Enforces a minimum idle gap before the next grant.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- CNT_W, 4, width of each per-requester pending-event counter.
- TIMEOUT, 64, cycles allowed in WAIT_ACK before abandoning a transaction (>=2).
- GAP_CYCLES, 2, idle cycles after each completed transaction (0 allowed).
- IDW, $clog2(NUM_REQ), width of o_id (derived).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_enable  input  1  allows new grants when high.
- i_req_pulse  input  NUM_REQ  one-cycle event pulse per requester.
- o_req_ovf  output  NUM_REQ  one-cycle flag: event dropped, counter saturated.
- o_pending  output  NUM_REQ  bit k high when counter k is nonzero.
- o_pulse  output  1  one-cycle pulse to pulse_sync input.
- o_id  output  IDW  granted requester; stable from ISSUE through end of WAIT_ACK.
- i_ack  input  1  acknowledge pulse returned across the domain.
- o_busy  output  1  high whenever state != IDLE.
- o_timeout  output  1  one-cycle flag: transaction abandoned.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; all counters 0.
  - RR pointer set so requester 0 has highest priority.
  - All outputs 0, including o_id.
- Counters:
  - i_req_pulse[k] increments counter k.
  - A grant to k decrements counter k on the IDLE->ISSUE edge.
  - Increment and decrement in the same cycle leave the count unchanged.
  - Increment at 2^CNT_W-1 with no decrement drops the event: counter holds, o_req_ovf[k]=1 for that cycle.
  - Counters accumulate in every state, including i_enable=0.
- FSM states: IDLE, ISSUE, WAIT_ACK, GAP.
- IDLE:
  - If i_enable=1 and any counter is nonzero, pick the first nonzero requester at or after pointer+1 (wrapping).
  - Register o_id, update pointer to the granted index, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: o_pulse=1 for exactly this cycle; clear ack timer; go to WAIT_ACK.
- WAIT_ACK:
  - Timer increments each cycle.
  - i_ack=1 -> GAP.
  - Otherwise, on the TIMEOUT-th cycle in WAIT_ACK: o_timeout=1 that cycle, then GAP.
  - Ack and timeout in the same cycle: ack wins, o_timeout stays 0.
- GAP:
  - Stay exactly GAP_CYCLES cycles, then go to IDLE.
  - GAP_CYCLES=0: GAP lasts zero cycles; WAIT_ACK exits directly to IDLE.
- i_ack outside WAIT_ACK is ignored, with no state or flag change.
- Latency: i_req_pulse sampled at edge E0, counter nonzero after E0, ISSUE entered at E1. o_pulse is high between E1 and E2.
- o_id retains the last grant in IDLE and GAP.
- i_enable deassert mid-transaction: the current transaction completes normally; no new grant is made until it is reasserted.
- Reset mid-transaction: all pending events are discarded. No o_pulse or o_timeout is emitted on release.
- o_pulse is never high in two consecutive cycles. Minimum spacing between pulses is 3+GAP_CYCLES cycles.

Test Plan:
- Single event:
  - Stimulus: after reset, pulse i_req_pulse[2] once; i_ack 10 cycles after o_pulse.
  - Required: o_pulse high 1 cycle, on the cycle after next, with o_id=2; o_busy high from ISSUE until 2 cycles after ack; o_pending=0000 at end.
- Round-robin:
  - Stimulus: pulse i_req_pulse=4'b1111 in one cycle; ack each grant after 5 cycles.
  - Required: grants in order 0,1,2,3, with gaps of exactly 2 idle cycles.
  - Follow-up: then pulse requesters 1 and 3 together; required grants are 1 then 3.
- Saturation:
  - Stimulus: i_enable=0, 17 pulses on requester 0.
  - Required: counter=15; o_req_ovf[0] high on the 16th and 17th pulses only.
  - Follow-up: set i_enable=1 with immediate acks; required is exactly 15 o_pulses with o_id=0.
- Timeout:
  - Stimulus: requesters 0 and 1 pending, no ack.
  - Required: o_timeout high exactly one cycle, at the 64th WAIT_ACK cycle; after GAP, requester 1 is granted.
- Coincidences:
  - i_ack on the 64th WAIT_ACK cycle: required o_timeout=0.
  - i_req_pulse[k] on the IDLE->ISSUE edge granting k: required counter k unchanged.
  - Stray i_ack in IDLE: required to be ignored.
- Reset mid-op:
  - Stimulus: assert rst_n low during WAIT_ACK with 3 events pending.
  - Required: all outputs 0 immediately (asynchronously); after release, no o_pulse until a new i_req_pulse.
